// File: rtl/ipdbg_pkg.sv
`default_nettype none
// =============================================================================
// Module : ipdbg_pkg
// Brief  : Shared symbols, FSM state types and channel IDs for the IPDBG
//          escape stage.
// Rev    : 1.0  initial release
// =============================================================================
package ipdbg_pkg;

  localparam logic [7:0] c_esc_symbol = 8'h55;
  localparam logic [7:0] c_rst_symbol = 8'hEE;

  // Function channel IDs on the JTAG hub
  localparam logic [3:0] c_chan_la     = 4'hC;
  localparam logic [3:0] c_chan_ioview = 4'hA;
  localparam logic [3:0] c_chan_gdb    = 4'h9;
  localparam logic [3:0] c_chan_wfg    = 4'hB;

  typedef enum logic [0:0] {
    DN_NORMAL  = 1'b0,
    DN_ESCAPED = 1'b1
  } dn_state_t;

  typedef enum logic [1:0] {
    UP_IDLE = 2'd0,
    UP_ESC  = 2'd1,
    UP_DATA = 2'd2
  } up_state_t;

  function automatic logic is_ctrl_symbol(input logic [7:0] b,
                                          input logic [7:0] esc,
                                          input logic [7:0] rst);
    return (b == esc) || (b == rst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipdbg_up_escaper.sv
`default_nettype none
// =============================================================================
// Module : ipdbg_up_escaper
// Brief  : Upstream escape inserter; prefixes colliding function bytes with
//          the escape symbol before they reach the hub.
// Rev    : 1.0  initial release
// =============================================================================
module ipdbg_up_escaper
  import ipdbg_pkg::*;
#(
  parameter logic [7:0] ESC_SYMBOL = c_esc_symbol,
  parameter logic [7:0] RST_SYMBOL = c_rst_symbol
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       func_rst,
  input  logic       flush,
  input  logic [7:0] up_data_in,
  input  logic       up_valid_in,
  output logic       up_ready_out,
  output logic [7:0] up_data_out,
  output logic       up_valid_out,
  input  logic       up_ready_in
);

  up_state_t  r_state, w_state_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_valid, w_valid_nxt;
  logic       w_accept;

  assign up_ready_out = (r_state != UP_ESC) && (!r_valid || up_ready_in) && !func_rst;
  assign w_accept     = up_valid_in && up_ready_out;
  assign up_data_out  = r_data;
  assign up_valid_out = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= UP_IDLE;
      r_data  <= 8'h00;
      r_hold  <= 8'h00;
      r_valid <= 1'b0;
    end else if (ce) begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_hold  <= w_hold_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_hold_nxt  = r_hold;
    w_valid_nxt = r_valid;
    if (flush) begin
      // Drops any half-sent escape pair together with the accepted byte
      w_state_nxt = UP_IDLE;
      w_data_nxt  = 8'h00;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        UP_ESC: begin
          if (up_ready_in) begin
            w_data_nxt  = r_hold;
            w_state_nxt = UP_DATA;
          end
        end
        default: begin
          if (r_valid && up_ready_in) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = UP_IDLE;
          end
          if (w_accept) begin
            w_valid_nxt = 1'b1;
            if (is_ctrl_symbol(up_data_in, ESC_SYMBOL, RST_SYMBOL)) begin
              w_data_nxt  = ESC_SYMBOL;
              w_hold_nxt  = up_data_in;
              w_state_nxt = UP_ESC;
            end else begin
              w_data_nxt  = up_data_in;
              w_state_nxt = UP_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipdbg_escape_stage.sv
`default_nettype none
// =============================================================================
// Module : ipdbg_escape_stage
// Brief  : Per-function hub stage: unescapes downstream bytes, turns the reset
//          symbol into a func_rst pulse, escapes upstream bytes.
// Config : IPDBG_UP_ESCAPE_EN enables upstream escape insertion
// Rev    : 1.0  initial release
// =============================================================================
module ipdbg_escape_stage
  import ipdbg_pkg::*;
#(
  parameter logic [7:0]  ESC_SYMBOL      = c_esc_symbol,
  parameter logic [7:0]  RST_SYMBOL      = c_rst_symbol,
  parameter int unsigned RESET_PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [7:0] dn_data_in,
  input  logic       dn_valid_in,
  output logic       dn_ready_out,
  output logic [7:0] dn_data_out,
  output logic       dn_valid_out,
  input  logic       dn_ready_in,
  input  logic [7:0] up_data_in,
  input  logic       up_valid_in,
  output logic       up_ready_out,
  output logic [7:0] up_data_out,
  output logic       up_valid_out,
  input  logic       up_ready_in,
  output logic       func_rst
);

  dn_state_t  r_dn_state, w_dn_state_nxt;
  logic [7:0] r_dn_data, w_dn_data_nxt;
  logic       r_dn_valid, w_dn_valid_nxt;
  logic [7:0] r_rst_cnt, w_rst_cnt_nxt;
  logic       w_dn_accept;
  logic       w_rst_seen;
  logic       w_up_flush;

  assign func_rst     = (r_rst_cnt != 8'd0);
  assign dn_ready_out = (!r_dn_valid || dn_ready_in) && !func_rst;
  assign w_dn_accept  = dn_valid_in && dn_ready_out;
  assign dn_data_out  = r_dn_data;
  assign dn_valid_out = r_dn_valid;
  // A reset symbol beats an upstream byte accepted on the same edge
  assign w_up_flush   = func_rst || w_rst_seen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dn_state <= DN_NORMAL;
      r_dn_data  <= 8'h00;
      r_dn_valid <= 1'b0;
      r_rst_cnt  <= 8'd0;
    end else if (ce) begin
      r_dn_state <= w_dn_state_nxt;
      r_dn_data  <= w_dn_data_nxt;
      r_dn_valid <= w_dn_valid_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
    end
  end

  always_comb begin
    w_dn_state_nxt = r_dn_state;
    w_dn_data_nxt  = r_dn_data;
    w_dn_valid_nxt = r_dn_valid;
    w_rst_cnt_nxt  = r_rst_cnt;
    w_rst_seen     = 1'b0;
    if (func_rst) begin
      w_rst_cnt_nxt  = r_rst_cnt - 8'd1;
      w_dn_state_nxt = DN_NORMAL;
      w_dn_data_nxt  = 8'h00;
      w_dn_valid_nxt = 1'b0;
    end else begin
      if (r_dn_valid && dn_ready_in) begin
        w_dn_valid_nxt = 1'b0;
      end
      if (w_dn_accept) begin
        if (r_dn_state == DN_ESCAPED) begin
          w_dn_data_nxt  = dn_data_in;
          w_dn_valid_nxt = 1'b1;
          w_dn_state_nxt = DN_NORMAL;
        end else if (dn_data_in == ESC_SYMBOL) begin
          w_dn_state_nxt = DN_ESCAPED;
        end else if (dn_data_in == RST_SYMBOL) begin
          w_rst_seen     = 1'b1;
          w_rst_cnt_nxt  = 8'(RESET_PULSE_LEN);
          w_dn_valid_nxt = 1'b0;
        end else begin
          w_dn_data_nxt  = dn_data_in;
          w_dn_valid_nxt = 1'b1;
        end
      end
    end
  end

`ifdef IPDBG_UP_ESCAPE_EN
  ipdbg_up_escaper #(
    .ESC_SYMBOL (ESC_SYMBOL),
    .RST_SYMBOL (RST_SYMBOL)
  ) u_up_escaper (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .func_rst     (func_rst),
    .flush        (w_up_flush),
    .up_data_in   (up_data_in),
    .up_valid_in  (up_valid_in),
    .up_ready_out (up_ready_out),
    .up_data_out  (up_data_out),
    .up_valid_out (up_valid_out),
    .up_ready_in  (up_ready_in)
  );
`else
  logic [7:0] r_up_data;
  logic       r_up_valid;

  assign up_ready_out = (!r_up_valid || up_ready_in) && !func_rst;
  assign up_data_out  = r_up_data;
  assign up_valid_out = r_up_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_up_data  <= 8'h00;
      r_up_valid <= 1'b0;
    end else if (ce) begin
      if (w_up_flush) begin
        r_up_data  <= 8'h00;
        r_up_valid <= 1'b0;
      end else if (up_valid_in && up_ready_out) begin
        r_up_data  <= up_data_in;
        r_up_valid <= 1'b1;
      end else if (up_ready_in) begin
        r_up_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ipdbg_escape_stage.sv
`default_nettype none
// =============================================================================
// Module : tb_ipdbg_escape_stage
// Brief  : Self-checking bench; byte-stream scoreboard plus directed scenarios.
// Rev    : 1.0  initial release
// =============================================================================
module tb_ipdbg_escape_stage;

  localparam logic [7:0] ESC   = 8'h55;
  localparam logic [7:0] RSTS  = 8'hEE;
  localparam int         PULSE = 4;

  typedef struct { logic [7:0] d; int c; } ev_t;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic [7:0] dn_data_in, up_data_in;
  logic       dn_valid_in, dn_ready_in, up_valid_in, up_ready_in;
  logic [7:0] dn_data_out, up_data_out;
  logic       dn_ready_out, dn_valid_out, up_ready_out, up_valid_out, func_rst;

  ipdbg_escape_stage #(
    .ESC_SYMBOL (ESC), .RST_SYMBOL (RSTS), .RESET_PULSE_LEN (PULSE)
  ) dut (
    .clk (clk), .rst (rst), .ce (ce),
    .dn_data_in (dn_data_in), .dn_valid_in (dn_valid_in), .dn_ready_out (dn_ready_out),
    .dn_data_out (dn_data_out), .dn_valid_out (dn_valid_out), .dn_ready_in (dn_ready_in),
    .up_data_in (up_data_in), .up_valid_in (up_valid_in), .up_ready_out (up_ready_out),
    .up_data_out (up_data_out), .up_valid_out (up_valid_out), .up_ready_in (up_ready_in),
    .func_rst (func_rst)
  );

  always #5 clk = ~clk;

  int         n_checks = 0, n_errors = 0, cyc = 0;
  logic [7:0] dn_q[$], up_q[$];
  bit         m_esc = 1'b0;
  int         m_pulse = 0;
  ev_t        dn_hist[$], up_hist[$];
  bit         tog_mode = 1'b0, dn_took, up_took;
  int         n_frst_ce, n_dnblk_ce, n_upblk_ce;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [7:0] rand_sym();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 25) return ESC;
    if (r < 30) return RSTS;
    return 8'($urandom);
  endfunction

  // One clock: check outputs against the byte-stream model, then advance it
  task automatic step();
    bit rst_ev;
    rst_ev  = 1'b0;
    if (tog_mode) ce = ~ce;
    #1;
    dn_took = 1'b0;
    up_took = 1'b0;
    check_eq("func_rst", func_rst, m_pulse != 0);
    check_eq("dn_ready_out", dn_ready_out, (!dn_valid_out || dn_ready_in) && m_pulse == 0);
    check_eq("dn_valid_out", dn_valid_out, dn_q.size() != 0);
    check_eq("up_valid_out", up_valid_out, up_q.size() != 0);
    check_eq("up_ready_out", up_ready_out,
             m_pulse == 0 && (up_q.size() == 0 || (up_q.size() == 1 && up_ready_in)));
    if (ce && dn_valid_out && dn_ready_in && dn_q.size() != 0) begin
      check_eq("dn_data_out", dn_data_out, dn_q.pop_front());
      dn_hist.push_back('{dn_data_out, cyc});
    end
    if (ce && up_valid_out && up_ready_in && up_q.size() != 0) begin
      check_eq("up_data_out", up_data_out, up_q.pop_front());
      up_hist.push_back('{up_data_out, cyc});
    end
    if (ce && dn_valid_in && dn_ready_out) begin
      dn_took = 1'b1;
      if (m_esc) begin
        dn_q.push_back(dn_data_in);
        m_esc = 1'b0;
      end else if (dn_data_in == ESC) m_esc = 1'b1;
      else if (dn_data_in == RSTS) rst_ev = 1'b1;
      else dn_q.push_back(dn_data_in);
    end
    if (ce && up_valid_in && up_ready_out) begin
      up_took = 1'b1;
      if (!rst_ev) begin
`ifdef IPDBG_UP_ESCAPE_EN
        if (up_data_in == ESC || up_data_in == RSTS) up_q.push_back(ESC);
`endif
        up_q.push_back(up_data_in);
      end
    end
    if (ce && m_pulse > 0) m_pulse--;
    if (rst_ev) begin
      dn_q.delete();
      up_q.delete();
      m_pulse = PULSE;
    end
    if (ce && func_rst) n_frst_ce++;
    if (ce && !dn_ready_out) n_dnblk_ce++;
    if (ce && !up_ready_out) n_upblk_ce++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_dn(input logic [7:0] b, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    dn_valid_in = 1'b1;
    dn_data_in  = b;
    for (int k = 0; k < 20 && !got; k++) begin
      at = cyc;
      step();
      got = dn_took;
    end
    dn_valid_in = 1'b0;
    check_eq("dn_accept", got, 1'b1);
  endtask

  task automatic send_up(input logic [7:0] b, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    up_valid_in = 1'b1;
    up_data_in  = b;
    for (int k = 0; k < 20 && !got; k++) begin
      at = cyc;
      step();
      got = up_took;
    end
    up_valid_in = 1'b0;
    check_eq("up_accept", got, 1'b1);
  endtask

  task automatic run_directed(input bit tog);
    int a0, a1, d;
    logic [7:0] ue[$];
    d = tog ? 2 : 1;
    tog_mode = tog;
    ce = 1'b1;
    dn_ready_in = 1'b1; up_ready_in = 1'b1;
    dn_valid_in = 1'b0; up_valid_in = 1'b0;

    dn_hist.delete(); n_frst_ce = 0;
    send_dn(8'h12, a0);
    send_dn(8'h34, a1);
    idle(6);
    check_eq("t1_count", dn_hist.size(), 2);
    if (dn_hist.size() == 2) begin
      check_eq("t1_byte0", dn_hist[0].d, 8'h12);
      check_eq("t1_lat0", dn_hist[0].c - a0, d);
      check_eq("t1_byte1", dn_hist[1].d, 8'h34);
      check_eq("t1_lat1", dn_hist[1].c - a1, d);
    end
    check_eq("t1_func_rst", n_frst_ce, 0);

    dn_hist.delete(); n_frst_ce = 0;
    send_dn(ESC, a0); send_dn(ESC, a0); send_dn(ESC, a0); send_dn(RSTS, a0);
    idle(6);
    check_eq("t2_count", dn_hist.size(), 2);
    if (dn_hist.size() == 2) begin
      check_eq("t2_byte0", dn_hist[0].d, ESC);
      check_eq("t2_byte1", dn_hist[1].d, RSTS);
    end
    check_eq("t2_func_rst", n_frst_ce, 0);

    n_frst_ce = 0; n_dnblk_ce = 0; n_upblk_ce = 0;
    send_dn(RSTS, a0);
    idle(12);
    check_eq("t3_func_rst_len", n_frst_ce, PULSE);
    check_eq("t3_dn_ready_low", n_dnblk_ce, PULSE);
    check_eq("t3_up_ready_low", n_upblk_ce, PULSE);

    up_hist.delete();
`ifdef IPDBG_UP_ESCAPE_EN
    ue = '{ESC, ESC, ESC, RSTS, 8'h01};
`else
    ue = '{ESC, RSTS, 8'h01};
`endif
    send_up(ESC, a0);
    send_up(RSTS, a1);
    send_up(8'h01, a1);
    idle(8);
    check_eq("t4_count", up_hist.size(), ue.size());
    if (up_hist.size() == ue.size()) begin
      check_eq("t4_first_lat", up_hist[0].c - a0, d);
      for (int i = 0; i < ue.size(); i++) begin
        check_eq("t4_byte", up_hist[i].d, ue[i]);
        if (i > 0) check_eq("t4_gap", up_hist[i].c - up_hist[i-1].c, d);
      end
    end
    tog_mode = 1'b0;
    ce = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [7:0] first_up;
    rst = 1'b0; ce = 1'b1;
    dn_data_in = 8'h00; dn_valid_in = 1'b0; dn_ready_in = 1'b1;
    up_data_in = 8'h00; up_valid_in = 1'b0; up_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_dn_valid", dn_valid_out, 1'b0);
    check_eq("rst_dn_data", dn_data_out, 8'h00);
    check_eq("rst_up_valid", up_valid_out, 1'b0);
    check_eq("rst_up_data", up_data_out, 8'h00);
    check_eq("rst_func_rst", func_rst, 1'b0);
    rst = 1'b1;

    run_directed(1'b0);
    run_directed(1'b1);

`ifdef IPDBG_UP_ESCAPE_EN
    first_up = ESC;
`else
    first_up = RSTS;
`endif
    up_ready_in = 1'b0;
    send_up(RSTS, a0);
    repeat (3) begin
      step();
      check_eq("t5_up_valid", up_valid_out, 1'b1);
      check_eq("t5_up_data", up_data_out, first_up);
      check_eq("t5_up_ready", up_ready_out, 1'b0);
    end
    up_ready_in = 1'b1;
    idle(6);

    // Asynchronous reset in the middle of an escape pair
    up_ready_in = 1'b0; dn_ready_in = 1'b0;
    send_dn(8'h21, a0);
    send_up(RSTS, a0);
    step();
    #2 rst = 1'b0;
    #1;
    check_eq("arst_up_valid", up_valid_out, 1'b0);
    check_eq("arst_up_data", up_data_out, 8'h00);
    check_eq("arst_dn_valid", dn_valid_out, 1'b0);
    check_eq("arst_dn_data", dn_data_out, 8'h00);
    check_eq("arst_func_rst", func_rst, 1'b0);
    dn_q.delete(); up_q.delete(); m_esc = 1'b0; m_pulse = 0;
    @(negedge clk);
    rst = 1'b1;
    dn_ready_in = 1'b1; up_ready_in = 1'b1;
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      ce          = ($urandom_range(0, 9) != 0);
      dn_valid_in = ($urandom_range(0, 1) == 1);
      dn_data_in  = rand_sym();
      dn_ready_in = ($urandom_range(0, 9) < 7);
      up_valid_in = ($urandom_range(0, 9) < 6);
      up_data_in  = rand_sym();
      up_ready_in = ($urandom_range(0, 9) < 7);
      step();
    end
    ce = 1'b1; dn_valid_in = 1'b0; up_valid_in = 1'b0;
    dn_ready_in = 1'b1; up_ready_in = 1'b1;
    idle(10);
    check_eq("drain_dn", dn_q.size(), 0);
    check_eq("drain_up", up_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
